// File: rtl/uart_pkg.sv
// Shared definitions for the UART report path: line-ending characters,
// the formatter state encoding and the nibble-to-ASCII helper.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_t;

  // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase)
  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/hex_line_tx.sv
// Renders one binary word per handshake as an ASCII hex line (optional tag,
// MSB nibble first, CR/LF) and feeds it character by character to uart_tx.
module hex_line_tx
  import uart_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int PREFIX_EN = 1,
  parameter int EOL_CRLF  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic [7:0]        tag_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              tx_ready,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              msg_done_tick
);

  localparam int NIB   = WORD_W / 4;
  localparam int LEN   = PREFIX_EN + NIB + ((EOL_CRLF != 0) ? 2 : 1);
  localparam int IDX_W = $clog2(LEN);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
  localparam logic [IDX_W-1:0] LAST_NIB = IDX_W'(PREFIX_EN + NIB - 1);
  localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(LEN - 2);

  tx_state_t         state, state_nxt;
  logic [WORD_W-1:0] shift_q;
  logic [7:0]        tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        cur_char;
  logic              is_tag, is_nib;
  logic              accept, fire, last, step;

  // Character select: the tag only ever sits at index 0, so nibbles are
  // everything after it up to LAST_NIB; the line ending follows.
  always_comb begin
    is_tag = (PREFIX_EN != 0) && (idx_q == '0);
    is_nib = !is_tag && (idx_q <= LAST_NIB);
    if (is_tag)                               cur_char = tag_q;
    else if (is_nib)                          cur_char = hex2ascii(shift_q[WORD_W-1 -: 4]);
    else if ((EOL_CRLF != 0) && (idx_q == CR_IDX)) cur_char = ASCII_CR;
    else                                      cur_char = ASCII_LF;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fire      = 1'b0;
    last      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: if (word_valid) begin
        accept    = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: if (tx_ready) begin
        fire      = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (tx_done_tick) begin
        if (idx_q == LAST_IDX) begin
          last      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          step      = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q       <= '0;
      tag_q         <= '0;
      idx_q         <= '0;
      tx_start      <= 1'b0;
      tx_data       <= '0;
      msg_done_tick <= 1'b0;
    end else begin
      tx_start      <= fire;
      msg_done_tick <= last;
      if (fire) tx_data <= cur_char;
      if (accept) begin
        shift_q <= word_in;
        tag_q   <= tag_in;
        idx_q   <= '0;
      end else if (step) begin
        idx_q <= idx_q + IDX_W'(1);
        // is_nib still reflects the character that just completed
        if (is_nib) shift_q <= shift_q << 4;
      end
    end
  end

  assign word_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);

endmodule
